// File: rtl/lii_in_unpack_fifo_if.sv
// Beat-level handshake bundle between the LII phy input channel, the unpack FIFO and the kernel stream.
// slave = the FIFO side; master = whoever drives the phy beats and consumes the kernel stream.
interface lii_in_unpack_fifo_if #(
    parameter int PW = 1024,
    parameter int DW = 8
);
    logic [PW-1:0] lii_in_p0_tdata;
    logic          lii_in_p0_tvalid;
    logic          lii_in_p0_tready;
    logic [7:0]    lii_in_p0_src;
    logic [7:0]    lii_in_p0_dst;
    logic [DW-1:0] out_stream_tdata;
    logic          out_stream_tvalid;
    logic          out_stream_tready;

    modport slave (
        input  lii_in_p0_tdata, lii_in_p0_tvalid, lii_in_p0_src, lii_in_p0_dst, out_stream_tready,
        output lii_in_p0_tready, out_stream_tdata, out_stream_tvalid
    );

    modport master (
        output lii_in_p0_tdata, lii_in_p0_tvalid, lii_in_p0_src, lii_in_p0_dst, out_stream_tready,
        input  lii_in_p0_tready, out_stream_tdata, out_stream_tvalid
    );
endinterface

// File: rtl/lii_in_unpack_fifo.sv
// Filters LII input beats by destination ID and unpacks tdata[DW-1:0] into a FWFT FIFO for the kernel.
// Latency: a beat accepted at edge N is at the FIFO head after edge N; no comb input-to-output path.
// Backpressure: tready drops only when the FIFO is full (registered state); misrouted beats are consumed and counted.
module lii_in_unpack_fifo #(
    parameter int         PW        = 1024,
    parameter int         DW        = 8,
    parameter int         DEPTH     = 4,
    parameter logic [7:0] LOCAL_ID  = 8'h01,
    parameter bit         CHECK_DST = 1'b1
) (
    input  logic                       aclk,
    input  logic                       arst,
    lii_in_unpack_fifo_if.slave        bus,
    output logic                       ce,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic [15:0]                drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [DW-1:0] mem [DEPTH];

    logic full;
    logic in_rdy;
    logic out_vld;
    logic acc;
    logic match;
    logic push;
    logic drop;
    logic pop;

    assign full    = (count == CW'(DEPTH));
    assign in_rdy  = !arst && !full;
    assign out_vld = !arst && (count != '0);

    assign acc   = bus.lii_in_p0_tvalid && in_rdy;
    assign match = !CHECK_DST || (bus.lii_in_p0_dst == LOCAL_ID);
    assign push  = acc && match;
    assign drop  = acc && !match;
    assign pop   = out_vld && bus.out_stream_tready;

    assign bus.lii_in_p0_tready  = in_rdy;
    assign bus.out_stream_tvalid = out_vld;
    assign bus.out_stream_tdata  = mem[rd_ptr];
    assign ce                    = out_vld;
    assign fill_level            = count;

    always_ff @(posedge aclk) begin
        if (arst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            // Saturate so a long misrouting storm never wraps back to a small value.
            if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
        end
    end

    // Storage needs no reset: entries are only observable once count covers them.
    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr] <= bus.lii_in_p0_tdata[DW-1:0];
    end

    // Source ID and the packed bits above DW carry nothing this stage consumes.
    generate
        if (DW < PW) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^{bus.lii_in_p0_src, bus.lii_in_p0_tdata[PW-1:DW]};
        end else begin : g_nopad
            logic unused_pad;
            assign unused_pad = ^bus.lii_in_p0_src;
        end
    endgenerate
endmodule

// File: tb/tb_lii_in_unpack_fifo.sv
// Drives a filtering instance and a pass-all instance with identical beats; a queue model predicts both.
module tb_lii_in_unpack_fifo;
    localparam int         PW    = 1024;
    localparam int         DW    = 8;
    localparam int         DEPTH = 4;
    localparam logic [7:0] LID   = 8'h01;

    logic aclk = 1'b0;
    logic arst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    lii_in_unpack_fifo_if #(.PW(PW), .DW(DW)) if0 ();
    lii_in_unpack_fifo_if #(.PW(PW), .DW(DW)) if1 ();

    logic        ce0, ce1;
    logic [2:0]  fill0, fill1;
    logic [15:0] drop0, drop1;

    lii_in_unpack_fifo #(.PW(PW), .DW(DW), .DEPTH(DEPTH), .LOCAL_ID(LID), .CHECK_DST(1'b1)) u_chk (
        .aclk(aclk), .arst(arst), .bus(if0.slave), .ce(ce0), .fill_level(fill0), .drop_count(drop0));

    lii_in_unpack_fifo #(.PW(PW), .DW(DW), .DEPTH(DEPTH), .LOCAL_ID(LID), .CHECK_DST(1'b0)) u_all (
        .aclk(aclk), .arst(arst), .bus(if1.slave), .ce(ce1), .fill_level(fill1), .drop_count(drop1));

    always #5 aclk = ~aclk;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         mdrop0 = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, check pre-edge outputs against the model, advance the model at the edge.
    task automatic cycle(input logic rst, input logic vld, input logic [7:0] dst,
                         input logic [7:0] data, input logic ordy);
        logic [PW-1:0] td;
        logic r0, r1, v0, v1;
        td = {32{$urandom()}};
        td[7:0] = data;
        arst = rst;
        if0.lii_in_p0_tdata = td;   if1.lii_in_p0_tdata = td;
        if0.lii_in_p0_tvalid = vld; if1.lii_in_p0_tvalid = vld;
        if0.lii_in_p0_dst = dst;    if1.lii_in_p0_dst = dst;
        if0.lii_in_p0_src = 8'h3C;  if1.lii_in_p0_src = 8'h3C;
        if0.out_stream_tready = ordy; if1.out_stream_tready = ordy;
        #1;
        r0 = !rst && (q0.size() != DEPTH);
        r1 = !rst && (q1.size() != DEPTH);
        v0 = !rst && (q0.size() != 0);
        v1 = !rst && (q1.size() != 0);
        chk("tready0", if0.lii_in_p0_tready, r0);
        chk("tvalid0", if0.out_stream_tvalid, v0);
        chk("ce0", ce0, v0);
        chk("fill0", fill0, q0.size());
        chk("drop0", drop0, mdrop0);
        if (v0) chk("tdata0", if0.out_stream_tdata, q0[0]);
        chk("tready1", if1.lii_in_p0_tready, r1);
        chk("tvalid1", if1.out_stream_tvalid, v1);
        chk("ce1", ce1, v1);
        chk("fill1", fill1, q1.size());
        chk("drop1", drop1, 0);
        if (v1) chk("tdata1", if1.out_stream_tdata, q1[0]);
        @(posedge aclk);
        if (rst) begin
            q0.delete();
            q1.delete();
            mdrop0 = 0;
        end else begin
            if (v0 && ordy) void'(q0.pop_front());
            if (v1 && ordy) void'(q1.pop_front());
            if (vld && r0) begin
                if (dst == LID) q0.push_back(data);
                else if (mdrop0 != 16'hFFFF) mdrop0++;
            end
            if (vld && r1) q1.push_back(data);
        end
        #1;
    endtask

    initial begin
        if0.lii_in_p0_tvalid = 1'b0; if1.lii_in_p0_tvalid = 1'b0;
        if0.out_stream_tready = 1'b0; if1.out_stream_tready = 1'b0;
        if0.lii_in_p0_tdata = '0; if1.lii_in_p0_tdata = '0;
        if0.lii_in_p0_dst = '0; if1.lii_in_p0_dst = '0;
        if0.lii_in_p0_src = '0; if1.lii_in_p0_src = '0;
        repeat (2) @(posedge aclk);
        #1;

        // Reset held two cycles, then idle
        cycle(1, 0, LID, 8'h00, 0);
        cycle(1, 1, LID, 8'h99, 1);
        cycle(0, 0, LID, 8'h00, 0);
        chk("idle_tready", if0.lii_in_p0_tready, 1'b1);

        // Single beat with held output
        cycle(0, 1, LID, 8'hA5, 0);
        chk("single_data", if0.out_stream_tdata, 8'hA5);
        chk("single_fill", fill0, 3'd1);
        chk("single_ce", ce0, 1'b1);
        cycle(0, 0, LID, 8'h00, 1);
        cycle(0, 0, LID, 8'h00, 0);

        // Fill to DEPTH, fifth beat held until a pop frees a slot
        for (int i = 0; i < 4; i++) cycle(0, 1, LID, 8'h10 + 8'(i), 0);
        chk("full_fill", fill0, 3'd4);
        chk("full_tready", if0.lii_in_p0_tready, 1'b0);
        cycle(0, 1, LID, 8'h14, 0);
        cycle(0, 1, LID, 8'h14, 1);
        cycle(0, 1, LID, 8'h14, 0);
        chk("refill_fill", fill0, 3'd4);
        for (int i = 0; i < 6; i++) cycle(0, 0, LID, 8'h00, 1);

        // Destination filtering; pass-all instance sees every beat
        cycle(0, 1, LID,   8'h01, 1);
        cycle(0, 1, 8'h07, 8'hEE, 1);
        cycle(0, 1, LID,   8'h02, 1);
        cycle(0, 1, 8'h07, 8'hEE, 1);
        cycle(0, 1, 8'h07, 8'hEE, 1);
        chk("filter_drops", drop0, 16'd3);
        for (int i = 0; i < 6; i++) cycle(0, 0, LID, 8'h00, 1);

        // Concurrent push/pop at fill level 2, across pointer wrap
        cycle(0, 1, LID, 8'h20, 0);
        cycle(0, 1, LID, 8'h21, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, LID, 8'h22 + 8'(i), 1);
            chk("conc_fill", fill0, 3'd2);
        end
        for (int i = 0; i < 4; i++) cycle(0, 0, LID, 8'h00, 1);

        // Reset mid-stream discards buffered entries
        for (int i = 0; i < 3; i++) cycle(0, 1, LID, 8'h40 + 8'(i), 0);
        chk("pre_rst_fill", fill0, 3'd3);
        cycle(1, 0, LID, 8'h00, 0);
        chk("rst_fill", fill0, 3'd0);
        chk("rst_tvalid", if0.out_stream_tvalid, 1'b0);
        cycle(0, 1, LID, 8'h55, 0);
        chk("post_rst_head", if0.out_stream_tdata, 8'h55);
        cycle(0, 0, LID, 8'h00, 1);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 500; i++) begin
            cycle(($urandom_range(0, 99) == 0),
                  1'($urandom()),
                  ($urandom_range(0, 3) == 0) ? 8'($urandom()) : LID,
                  8'($urandom()),
                  ($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 6; i++) cycle(0, 0, LID, 8'h00, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
